seg7_scan_driver: RTL

//  Display back-end of the 7-segment AXI4-Lite peripheral.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_prescaler.sv | 28 ++
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan display.
// Latency: n/a (types and a pure function); backpressure: n/a.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam int   PHASE_W   = 4;

    // Segment order is gfedcba, so bit0 drives segment a.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Scan-tick generator: counts cycles and pulses tick once cnt reaches div, then restarts.
// Latency: tick is combinational from cnt and div; backpressure: none, clr holds cnt at 0.
module seg7_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Compare with >= so lowering div below the running count ticks immediately.
    assign tick = ~clr & (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display back-end with PWM brightness and frame-aligned shadow updates.
// Latency: pins follow counter state by 1 cycle; backpressure: none, update_i is held pending until frame wrap.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_W          = 16,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    enable_i,
    input  logic [3:0]              bright_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic                    update_i,
    output seg_t                    seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o,
    output logic                    pending_o
);

    localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_OFF  = ACTIVE_LOW_SEG ? ~SEG_BLANK : SEG_BLANK;
    localparam logic                  DP_OFF   = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic                    tick;
    logic                    wrap;
    logic                    lit;
    logic [PHASE_W-1:0]      phase;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] digit_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [3:0]              digit_cur;
    seg_t                    seg_cur;
    logic [NUM_DIGITS-1:0]   an_sel;

    seg7_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clr   (~enable_i),
        .div   (div_i),
        .tick  (tick)
    );

    assign wrap      = tick && (phase == {PHASE_W{1'b1}}) && (idx == IDX_LAST);
    assign digit_cur = digit_sh[4*int'(idx) +: 4];
    assign seg_cur   = hex_to_seg(digit_cur);
    assign an_sel    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    assign lit       = enable_i && !blank_sh[idx] && (phase < bright_i);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            phase   <= '0;
            idx     <= '0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= wrap;
            if (!enable_i) begin
                phase <= '0;
                idx   <= '0;
            end else if (tick) begin
                phase <= phase + 1'b1;
                if (phase == {PHASE_W{1'b1}}) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // A request arriving in the wrap cycle itself is taken immediately and never shows as pending.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            digit_sh  <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            pending_o <= 1'b0;
        end else if (wrap) begin
            if (pending_o || update_i) begin
                digit_sh <= digits_i;
                dp_sh    <= dp_i;
                blank_sh <= blank_i;
            end
            pending_o <= 1'b0;
        end else if (update_i) begin
            pending_o <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
        end else if (lit) begin
            an_o  <= ACTIVE_LOW_AN ? ~an_sel : an_sel;
            seg_o <= ACTIVE_LOW_SEG ? ~seg_cur : seg_cur;
            dp_o  <= dp_sh[idx] ^ DP_OFF;
        end else begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
        end
    end

endmodule
